truth_table_sweeper: RTL and testbench

//   Sequencer that characterises one 3-input logic gate, such as the 0xE2 gate.
//   - On start, drives all 8 input combinations {in1,in2,in3} = 000..111 in order.
//   - Holds each vector for SETTLE cycles, then samples the gate output.
//   - Assembles an 8-bit truth-table code and compares it with EXPECTED.
//   - Sits between the test/config controller and a single gate instance.
//

---
 rtl/truth_table_sweeper.sv | 126 ++++++++++++
 tb/tb_truth_table_sweeper.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/truth_table_sweeper.sv
// rtl/truth_table_sweeper.sv - sequencer that sweeps a 3-input gate and checks its truth table
//
// Purpose: on start, drives the eight input vectors 000..111 onto one gate,
// holds each for SETTLE cycles, captures gate_out on the last held cycle and
// assembles an 8-bit truth-table code (bit 7 = input 000, bit 0 = input 111).
//
// Ports:
//   clk           in   clock, rising edge
//   rst           in   asynchronous active-high reset
//   start         in   one-cycle sweep request, honoured only in IDLE
//   abort         in   cancels a running sweep
//   gate_out      in   output of the gate under control
//   in1,in2,in3   out  gate input vector, in1 is the MSB
//   busy          out  high while vectors are being driven
//   done          out  one-cycle completion pulse
//   result_valid  out  high from done until the next start, abort or reset
//   table_out     out  assembled truth-table code
//   match         out  table_out equals EXPECTED and result is valid

module truth_table_sweeper #(
  parameter int         SETTLE   = 4,
  parameter logic [7:0] EXPECTED = 8'hE2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       gate_out,
  output logic       in1,
  output logic       in2,
  output logic       in3,
  output logic       busy,
  output logic       done,
  output logic       result_valid,
  output logic [7:0] table_out,
  output logic       match
);

  localparam int             CW     = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  RELOAD = CW'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_DONE
  } state_t;

  state_t        state, state_d;
  logic [2:0]    idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [7:0]    table_q, table_d;
  logic          rv_q, rv_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      idx     <= 3'd0;
      cnt     <= '0;
      table_q <= 8'd0;
      rv_q    <= 1'b0;
    end else begin
      state   <= state_d;
      idx     <= idx_d;
      cnt     <= cnt_d;
      table_q <= table_d;
      rv_q    <= rv_d;
    end
  end

  always_comb begin
    state_d = state;
    idx_d   = idx;
    cnt_d   = cnt;
    table_d = table_q;
    rv_d    = rv_q;
    case (state)
      ST_IDLE: begin
        // abort in the same cycle as start suppresses the sweep
        if (start && !abort) begin
          state_d = ST_SETTLE;
          idx_d   = 3'd0;
          cnt_d   = RELOAD;
          table_d = 8'd0;
          rv_d    = 1'b0;
        end
      end
      ST_SETTLE: begin
        if (abort) begin
          // partially captured bits stay in table_q
          state_d = ST_IDLE;
          idx_d   = 3'd0;
          cnt_d   = '0;
          rv_d    = 1'b0;
        end else if (cnt != '0) begin
          cnt_d = cnt - 1'b1;
        end else begin
          // last cycle of this vector's hold window: capture the gate output
          table_d[3'd7 - idx] = gate_out;
          if (idx != 3'd7) begin
            idx_d = idx + 3'd1;
            cnt_d = RELOAD;
          end else begin
            state_d = ST_DONE;
            idx_d   = 3'd0;
            rv_d    = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // vector is forced to 000 whenever no sweep is running
  assign {in1, in2, in3} = (state == ST_SETTLE) ? idx : 3'b000;
  assign busy            = (state == ST_SETTLE);
  assign done            = (state == ST_DONE);
  assign result_valid    = rv_q;
  assign table_out       = table_q;
  assign match           = rv_q && (table_q == EXPECTED);

endmodule

// File: tb/tb_truth_table_sweeper.sv
// tb/tb_truth_table_sweeper.sv - self-checking bench for truth_table_sweeper

module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] start, abort, gate_out;
  logic [1:0] in1, in2, in3, busy, done, rv, match;
  logic [7:0] tbl [2];
  logic [7:0] gate_code [2];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign gate_out[0] = gate_code[0][3'd7 - {in1[0], in2[0], in3[0]}];
  assign gate_out[1] = gate_code[1][3'd7 - {in1[1], in2[1], in3[1]}];

  truth_table_sweeper #(.SETTLE(4), .EXPECTED(8'hE2)) dut0 (
    .clk(clk), .rst(rst), .start(start[0]), .abort(abort[0]), .gate_out(gate_out[0]),
    .in1(in1[0]), .in2(in2[0]), .in3(in3[0]), .busy(busy[0]), .done(done[0]),
    .result_valid(rv[0]), .table_out(tbl[0]), .match(match[0])
  );

  truth_table_sweeper #(.SETTLE(1), .EXPECTED(8'hE2)) dut1 (
    .clk(clk), .rst(rst), .start(start[1]), .abort(abort[1]), .gate_out(gate_out[1]),
    .in1(in1[1]), .in2(in2[1]), .in3(in3[1]), .busy(busy[1]), .done(done[1]),
    .result_valid(rv[1]), .table_out(tbl[1]), .match(match[1])
  );

  // Model: k = cycles elapsed since the sweep was accepted; vector = k / S,
  // sample when k is the last cycle of a window; done when k reaches 8*S.
  int         s_of [2] = '{4, 1};
  bit         m_run [2] = '{0, 0};
  bit         m_done [2] = '{0, 0};
  bit         m_rv [2] = '{0, 0};
  int         m_k [2] = '{0, 0};
  logic [7:0] m_tbl [2] = '{8'd0, 8'd0};

  always @(posedge clk or posedge rst) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        m_run[d]  <= 1'b0;
        m_done[d] <= 1'b0;
        m_rv[d]   <= 1'b0;
        m_k[d]    <= 0;
        m_tbl[d]  <= 8'd0;
      end else if (m_run[d]) begin
        if (abort[d]) begin
          m_run[d] <= 1'b0;
          m_rv[d]  <= 1'b0;
          m_k[d]   <= 0;
        end else begin
          if (m_k[d] % s_of[d] == s_of[d] - 1)
            m_tbl[d][3'(7 - m_k[d] / s_of[d])] <= gate_code[d][3'(7 - m_k[d] / s_of[d])];
          m_k[d] <= m_k[d] + 1;
          if (m_k[d] + 1 == 8 * s_of[d]) begin
            m_run[d]  <= 1'b0;
            m_done[d] <= 1'b1;
            m_rv[d]   <= 1'b1;
          end
        end
      end else if (m_done[d]) begin
        m_done[d] <= 1'b0;
      end else if (start[d] && !abort[d]) begin
        m_run[d] <= 1'b1;
        m_k[d]   <= 0;
        m_tbl[d] <= 8'd0;
        m_rv[d]  <= 1'b0;
      end
    end
  end

  function automatic logic [14:0] got_bundle(input int d);
    return {in1[d], in2[d], in3[d], busy[d], done[d], rv[d], tbl[d], match[d]};
  endfunction

  function automatic logic [14:0] exp_bundle(input int d);
    return {(m_run[d] ? 3'(m_k[d] / s_of[d]) : 3'd0), m_run[d], m_done[d], m_rv[d],
            m_tbl[d], (m_rv[d] && (m_tbl[d] == 8'hE2))};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (!rst) begin
      check("cycle_dut0", 32'(got_bundle(0)), 32'(exp_bundle(0)));
      check("cycle_dut1", 32'(got_bundle(1)), 32'(exp_bundle(1)));
    end
  end

  task automatic run_sweep(input int d, output int cycles);
    @(negedge clk);
    start[d] = 1'b1;
    cycles = 0;
    while (cycles < 200) begin
      @(negedge clk);
      start[d] = 1'b0;
      cycles++;
      if (done[d]) break;
    end
    check("done_seen", 32'(done[d]), 32'd1);
  endtask

  task automatic wait_vec(input int d, input logic [2:0] v);
    int n = 0;
    while (n < 100 && {in1[d], in2[d], in3[d]} != v) begin
      @(negedge clk);
      n++;
    end
    check("vector_reached", 32'({in1[d], in2[d], in3[d]}), 32'(v));
  endtask

  task automatic count_done(input int d, input int span, output int pulses);
    pulses = 0;
    repeat (span) begin
      @(negedge clk);
      if (done[d]) pulses++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    int p;
    rst = 1'b1;
    start = 2'b00;
    abort = 2'b00;
    gate_code[0] = 8'hE2;
    gate_code[1] = 8'hE2;
    #3;
    check("reset_dut0", 32'(got_bundle(0)), 32'd0);
    check("reset_dut1", 32'(got_bundle(1)), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 1: nominal 0xE2 sweep with SETTLE=4
    run_sweep(0, c);
    check("t1_latency", 32'(c), 32'd33);
    check("t1_table", 32'(tbl[0]), 32'h0E2);
    check("t1_model_table", 32'(m_tbl[0]), 32'h0E2);
    check("t1_match", 32'(match[0]), 32'd1);
    @(negedge clk);
    check("t1_rv_hold", 32'({rv[0], done[0]}), 32'b10);

    // 2: gate forced high for input 111
    gate_code[0] = 8'hE3;
    run_sweep(0, c);
    check("t2_table", 32'(tbl[0]), 32'h0E3);
    check("t2_model_table", 32'(m_tbl[0]), 32'h0E3);
    check("t2_match_rv", 32'({match[0], rv[0]}), 32'b01);
    gate_code[0] = 8'hE2;

    // 3: start pulsed again at vector 011 is ignored
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_vec(0, 3'b011);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    count_done(0, 40, p);
    check("t3_done_pulses", 32'(p), 32'd1);
    check("t3_table", 32'(tbl[0]), 32'h0E2);

    // 4: abort during vector 100
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_vec(0, 3'b100);
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("t4_vec_busy_done_rv", 32'({in1[0], in2[0], in3[0], busy[0], done[0], rv[0]}), 32'd0);
    check("t4_table_hi", 32'(tbl[0][7:5]), 32'b111);
    check("t4_model_table_hi", 32'(m_tbl[0][7:5]), 32'b111);
    count_done(0, 40, p);
    check("t4_no_done", 32'(p), 32'd0);

    // abort and start together in IDLE: no sweep
    start[0] = 1'b1;
    abort[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    abort[0] = 1'b0;
    check("abort_wins", 32'(busy[0]), 32'd0);

    // 5: asynchronous reset during vector 101
    @(negedge clk);
    start[0] = 1'b1;
    @(negedge clk);
    start[0] = 1'b0;
    wait_vec(0, 3'b101);
    #2;
    rst = 1'b1;
    #1;
    check("t5_async_reset", 32'(got_bundle(0)), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_sweep(0, c);
    check("t5_latency", 32'(c), 32'd33);
    check("t5_table", 32'(tbl[0]), 32'h0E2);
    check("t5_match", 32'(match[0]), 32'd1);

    // 6: SETTLE=1, back-to-back sweeps started in the cycle after done
    run_sweep(1, c);
    check("t6a_latency", 32'(c), 32'd9);
    check("t6a_table_match", 32'({tbl[1], match[1]}), 32'({8'hE2, 1'b1}));
    run_sweep(1, c);
    check("t6b_latency", 32'(c), 32'd9);
    check("t6b_table_match", 32'({tbl[1], match[1]}), 32'({8'hE2, 1'b1}));
    check("t6_model_table", 32'(m_tbl[1]), 32'h0E2);

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
